dram_line_responder: RTL and testbench

//  Memory-side responder for the L1 cache's DRAM request/ack handshake; models the external DRAM.

---
 rtl/dram_line_responder_pkg.sv | 16 +
 rtl/dram_line_responder_array.sv | 26 ++
 rtl/dram_line_responder.sv | 156 +++++++++++++++
 tb/tb_dram_line_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dram_line_responder_pkg.sv
// Shared FSM state encodings and line-geometry helper for the DRAM line responder.
package dram_line_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ACK   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Byte-offset bits inside one cache line (LINE_W is a power of two, >= 8).
  function automatic int unsigned line_off(input int unsigned line_w);
    return $clog2(line_w / 8);
  endfunction

endpackage

// File: rtl/dram_line_responder_array.sv
// Single-port line storage: synchronous write, asynchronous read; no reset.
// Kept separate so a vendor RAM macro can be dropped in.
module dram_line_array
  import dram_line_responder_pkg::*;
#(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned IDX_W  = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] store [2**IDX_W];

  always_ff @(posedge clk) begin
    if (we) begin
      store[idx] <= wdata;
    end
  end

  assign rdata = store[idx];

endmodule

// File: rtl/dram_line_responder.sv
// DRAM model behind the L1 cache: one outstanding line read/write, fixed LATENCY, one-cycle ack.
// Optional protocol checker enabled by defining DRAM_PROTOCOL_CHECK_EN (messages with DEBUG).
module dram_line_responder
  import dram_line_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned IDX_W   = 10,
  parameter int unsigned LATENCY = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_cs,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              proto_err
);

  localparam int unsigned OFF   = line_off(LINE_W);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              we_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wdata_q;
  logic              accept, ack_nxt, arr_we, rd_load;
  logic [LINE_W-1:0] arr_rdata;
  logic              unused_addr;

  // Tag and offset bits of the address are deliberately ignored.
  assign unused_addr = ^mem_addr;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    ack_nxt   = 1'b0;
    arr_we    = 1'b0;
    rd_load   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (mem_cs) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_W'(LATENCY - 1);
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A dropped request wins even on the final countdown cycle.
        if (!mem_cs) begin
          state_nxt = ST_IDLE;
        end else if (cnt == '0) begin
          state_nxt = ST_ACK;
          ack_nxt   = 1'b1;
          arr_we    = we_q;
          rd_load   = !we_q;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_ACK: begin
        state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!mem_cs) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      mem_ack   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      mem_ack <= ack_nxt;
      if (accept) begin
        we_q <= mem_we;
      end
      if (rd_load) begin
        mem_rdata <= arr_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= mem_addr[OFF+IDX_W-1:OFF];
      wdata_q <= mem_wdata;
    end
  end

  dram_line_array #(
    .LINE_W (LINE_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

`ifdef DRAM_PROTOCOL_CHECK_EN
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;
  logic              viol_abort, viol_chg;

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= mem_addr;
    end
  end

  assign viol_abort = (state == ST_WAIT) && !mem_cs;
  assign viol_chg   = (state == ST_WAIT) && mem_cs &&
                      ((mem_we != we_q) || (mem_addr != addr_q) || (mem_wdata != wdata_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (viol_abort || viol_chg) begin
      err_q <= 1'b1;
    end
  end

`ifdef DEBUG
  always_ff @(posedge clk) begin
    if (rst && viol_chg) begin
      $display("dram_line_responder: request fields changed during WAIT at %0t", $time);
    end
    if (rst && viol_abort) begin
      $display("dram_line_responder: request dropped during WAIT at %0t", $time);
    end
  end
`endif

  assign proto_err = err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_dram_line_responder.sv
// Scoreboard bench for dram_line_responder: LATENCY=10 instance plus a LATENCY=1 instance.
module tb_dram_line_responder;

  localparam int LW  = 256;
  localparam int LAT = 10;
`ifdef DRAM_PROTOCOL_CHECK_EN
  localparam logic PE_EXP = 1'b1;
`else
  localparam logic PE_EXP = 1'b0;
`endif

  typedef struct {
    logic          rd;
    logic [LW-1:0] data;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cs = 1'b0, we = 1'b0, cs1 = 1'b0, we1 = 1'b0;
  logic [31:0]   addr = '0, addr1 = '0;
  logic [LW-1:0] wdata = '0, wdata1 = '0;
  logic [LW-1:0] rdata, rdata1;
  logic          ack, ack1, perr, perr1;

  exp_t q0[$];
  exp_t q1[$];
  int   ack_cnt [2];
  logic prev_ack [2];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dram_line_responder #(.ADDR_W(32), .LINE_W(LW), .IDX_W(10), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .mem_cs(cs), .mem_we(we), .mem_addr(addr),
    .mem_wdata(wdata), .mem_rdata(rdata), .mem_ack(ack), .proto_err(perr));

  dram_line_responder #(.ADDR_W(32), .LINE_W(LW), .IDX_W(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_cs(cs1), .mem_we(we1), .mem_addr(addr1),
    .mem_wdata(wdata1), .mem_rdata(rdata1), .mem_ack(ack1), .proto_err(perr1));

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input int d, input logic c, input logic w, input logic [31:0] a,
                       input logic [LW-1:0] wd);
    if (d == 0) begin
      cs = c; we = w; addr = a; wdata = wd;
    end else begin
      cs1 = c; we1 = w; addr1 = a; wdata1 = wd;
    end
  endtask

  // Monitor: every ack pops one expected entry and is checked against it.
  task automatic mon_step(input int d, input logic a, input logic [LW-1:0] r);
    exp_t e;
    int   sz;
    if (a) begin
      ack_cnt[d]++;
      chk("ack_width", prev_ack[d], 0);
      sz = (d == 0) ? q0.size() : q1.size();
      chk("ack_expected", sz > 0, 1);
      if (sz > 0) begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk("ack_latency", cyc, e.cyc);
        if (e.rd) chk("rdata", r, e.data);
      end
    end
    prev_ack[d] = a;
  endtask

  initial begin
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    prev_ack[0] = 1'b0; prev_ack[1] = 1'b0;
  end

  always @(negedge clk) begin
    mon_step(0, ack, rdata);
    mon_step(1, ack1, rdata1);
  end

  task automatic req(input int d, input logic w, input logic [31:0] a, input logic [LW-1:0] wd,
                     input logic [LW-1:0] rexp, input int hold);
    exp_t e;
    int   base, lat;
    logic seen;
    lat  = (d == 0) ? LAT : 1;
    base = ack_cnt[d];
    @(negedge clk);
    drive(d, 1'b1, w, a, wd);
    e.rd = !w; e.data = rexp; e.cyc = cyc + 1 + lat;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < lat + 8 && !seen; i++) begin
      @(negedge clk);
      seen = (d == 0) ? ack : ack1;
    end
    chk("ack_seen", seen, 1);
    repeat (hold) @(negedge clk);
    drive(d, 1'b0, w, a, wd);
    repeat (2) @(negedge clk);
    chk("ack_count", ack_cnt[d] - base, 1);
  endtask

  initial begin
    logic [LW-1:0] l_a5, l_1234, l_dead, l_c3, l_3c, l_p;
    int base;
    l_a5   = {32{8'hA5}};
    l_1234 = {16{16'h1234}};
    l_dead = {8{32'hDEADBEEF}};
    l_c3   = {32{8'hC3}};
    l_3c   = {32{8'h3C}};
    l_p    = {4{64'h0123456789ABCDEF}};

    repeat (3) @(negedge clk);
    chk("reset_ack", ack, 0);
    chk("reset_rdata", rdata, '0);
    chk("reset_proto_err", perr, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Preload index 3 (addr 0x60), then read it back.
    req(0, 1'b1, 32'h60, l_a5, '0, 0);
    req(0, 1'b0, 32'h60, '0, l_a5, 0);
    // Overwrite, then read with offset bits set and without.
    req(0, 1'b1, 32'h60, l_1234, '0, 0);
    req(0, 1'b0, 32'h7F, '0, l_1234, 0);
    req(0, 1'b0, 32'h60, '0, l_1234, 0);
    // cs held 3 cycles past ack: exactly one ack, and the next request still works.
    req(0, 1'b0, 32'h60, '0, l_1234, 3);
    req(0, 1'b0, 32'h60, '0, l_1234, 0);
    chk("proto_err_clean", perr, 0);

    // Write aborted by dropping cs at accept+5.
    base = ack_cnt[0];
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h60, l_dead);
    repeat (5) @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h60, l_dead);
    repeat (LAT + 3) @(negedge clk);
    chk("abort_no_ack", ack_cnt[0] - base, 0);
    chk("abort_proto_err", perr, PE_EXP);
    req(0, 1'b0, 32'h60, '0, l_1234, 0);

    // Reset in the middle of a write's WAIT.
    req(0, 1'b1, 32'h80, l_c3, '0, 0);
    req(0, 1'b0, 32'h80, '0, l_c3, 0);
    base = ack_cnt[0];
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h80, l_3c);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_ack", ack, 0);
    chk("rst_mid_rdata", rdata, '0);
    chk("rst_mid_proto_err", perr, 0);
    drive(0, 1'b0, 1'b0, 32'h0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    chk("rst_mid_no_ack", ack_cnt[0] - base, 0);
    req(0, 1'b0, 32'h80, '0, l_c3, 0);

    // LATENCY=1 instance: one-cycle latency and upper-address aliasing.
    req(1, 1'b1, 32'h60, l_p, '0, 0);
    req(1, 1'b0, 32'h60 + (32'd32 << 10), '0, l_p, 0);
    req(1, 1'b0, 32'h60, '0, l_p, 0);
    chk("lat1_proto_err", perr1, 0);

    repeat (3) @(negedge clk);
    chk("queues_drained", q0.size() + q1.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
